// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter_if
// Description : One requester port of the data-memory arbiter. It carries the
//               request/handshake side and the registered read-return side.
//   master : drives req, we, lock, addr, wdata; observes gnt, rvalid, rdata
//   slave  : the arbiter side of the same bundle
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 6
);
  logic              req;     // one access requested this cycle
  logic              we;      // 1 = write, 0 = read
  logic              lock;    // owner asks to keep the grant next cycle
  logic [ADDR_W-1:0] addr;    // word address
  logic [DATA_W-1:0] wdata;   // write data
  logic              gnt;     // access accepted this cycle (combinational)
  logic              rvalid;  // read data valid, one cycle after a read grant
  logic [DATA_W-1:0] rdata;   // registered read data

  modport master (output req, we, lock, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, lock, addr, wdata, output gnt, rvalid, rdata);
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Round-robin arbiter with bounded locking in front of a single
//               ported data memory (asynchronous read, write on clock edge).
//   clk          : rising-edge clock
//   rst_n        : asynchronous reset, active low
//   port0        : core load/store requester (slave modport)
//   port1        : debug/DMA requester (slave modport)
//   o_mem_addr   : memory Address (granted port, 0 when idle)
//   o_mem_wdata  : memory WriteData (granted port, 0 when idle)
//   o_mem_write  : memory MemWrite
//   o_mem_read   : memory MemRead
//   i_mem_rdata  : memory ReadData
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 6,
  parameter int MAX_LOCK = 4
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  dmem_arbiter_if.slave          port0,
  dmem_arbiter_if.slave          port1,
  output logic      [ADDR_W-1:0] o_mem_addr,
  output logic      [DATA_W-1:0] o_mem_wdata,
  output logic                   o_mem_write,
  output logic                   o_mem_read,
  input  wire logic [DATA_W-1:0] i_mem_rdata
);

  localparam int              CNT_W      = $clog2(MAX_LOCK + 1);
  localparam logic [CNT_W-1:0] c_max_lock = CNT_W'(MAX_LOCK);
  localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_LOCK0 = 2'd1,
    ST_LOCK1 = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic              r_last, w_last_nxt;
  logic [CNT_W-1:0]  r_lock_cnt, w_lock_cnt_nxt;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic              w_gnt0, w_gnt1;
  logic              r_rvalid0, r_rvalid1;
  logic [DATA_W-1:0] r_rdata0, r_rdata1;

  // lock_cnt counts grants already given in the current run. A grant that
  // brings it to MAX_LOCK is the owner's last one while the other port waits;
  // with no competitor the count simply saturates.
  assign w_cnt_inc = (r_lock_cnt >= c_max_lock) ? c_max_lock : r_lock_cnt + c_one;

  always_comb begin
    w_gnt0         = 1'b0;
    w_gnt1         = 1'b0;
    w_state_nxt    = r_state;
    w_last_nxt     = r_last;
    w_lock_cnt_nxt = r_lock_cnt;
    case (r_state)
      ST_ARB: begin
        // On a tie the port that did not win last time is served.
        w_gnt0 = port0.req & (~port1.req | r_last);
        w_gnt1 = port1.req & (~port0.req | ~r_last);
        if (w_gnt0) begin
          w_last_nxt     = 1'b0;
          w_lock_cnt_nxt = c_one;
          if (port0.lock && !(port1.req && c_one == c_max_lock)) w_state_nxt = ST_LOCK0;
        end else if (w_gnt1) begin
          w_last_nxt     = 1'b1;
          w_lock_cnt_nxt = c_one;
          if (port1.lock && !(port0.req && c_one == c_max_lock)) w_state_nxt = ST_LOCK1;
        end
      end
      ST_LOCK0: begin
        w_gnt0 = port0.req;
        if (port0.req) begin
          w_lock_cnt_nxt = w_cnt_inc;
          w_last_nxt     = 1'b0;
        end
        if (!port0.lock || !port0.req || (port1.req && w_cnt_inc == c_max_lock))
          w_state_nxt = ST_ARB;
      end
      ST_LOCK1: begin
        w_gnt1 = port1.req;
        if (port1.req) begin
          w_lock_cnt_nxt = w_cnt_inc;
          w_last_nxt     = 1'b1;
        end
        if (!port1.lock || !port1.req || (port0.req && w_cnt_inc == c_max_lock))
          w_state_nxt = ST_ARB;
      end
      default: w_state_nxt = ST_ARB;
    endcase
    // No access may be issued while reset is held, even before the first edge.
    if (!rst_n) begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
    end
  end

  always_comb begin
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (w_gnt0) begin
      o_mem_addr  = port0.addr;
      o_mem_wdata = port0.wdata;
    end else if (w_gnt1) begin
      o_mem_addr  = port1.addr;
      o_mem_wdata = port1.wdata;
    end
    o_mem_write = (w_gnt0 & port0.we)  | (w_gnt1 & port1.we);
    o_mem_read  = (w_gnt0 & ~port0.we) | (w_gnt1 & ~port1.we);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_ARB;
      r_last     <= 1'b1;
      r_lock_cnt <= '0;
      r_rvalid0  <= 1'b0;
      r_rvalid1  <= 1'b0;
      r_rdata0   <= '0;
      r_rdata1   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_last     <= w_last_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
      r_rvalid0  <= w_gnt0 & ~port0.we;
      r_rvalid1  <= w_gnt1 & ~port1.we;
      if (w_gnt0 && !port0.we) r_rdata0 <= i_mem_rdata;
      if (w_gnt1 && !port1.we) r_rdata1 <= i_mem_rdata;
    end
  end

  assign port0.gnt    = w_gnt0;
  assign port0.rvalid = r_rvalid0;
  assign port0.rdata  = r_rdata0;
  assign port1.gnt    = w_gnt1;
  assign port1.rvalid = r_rvalid1;
  assign port1.rdata  = r_rdata1;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Self-checking bench for dmem_arbiter. Directed scenarios plus
//               constrained-random traffic, compared cycle by cycle against a
//               behavioural reference model of arbitration and memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 6;
  localparam int MAX_LOCK = 4;
  localparam int DEPTH    = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) p0 ();
  dmem_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) p1 ();

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              mem_write, mem_read;

  // Environment memory: asynchronous read, write on the rising edge.
  logic [DATA_W-1:0] mem [DEPTH];
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;

  dmem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_LOCK(MAX_LOCK)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .port0      (p0),
    .port1      (p1),
    .o_mem_addr (mem_addr),
    .o_mem_wdata(mem_wdata),
    .o_mem_write(mem_write),
    .o_mem_read (mem_read),
    .i_mem_rdata(mem_rdata)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [DATA_W-1:0] obs,
                           input logic [DATA_W-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: who currently holds a lock run, how many grants that
  // run has had, the last winner, the memory image and the pending read data.
  int                m_last;
  int                m_owner;
  int                m_streak;
  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic              exp_rvalid [2];
  logic [DATA_W-1:0] exp_rdata  [2];
  logic [1:0]        m_gnt;
  logic [1:0]        obs_gnt;

  // Requester stimulus
  logic              c_req [2], c_we [2], c_lock [2];
  logic [ADDR_W-1:0] c_addr [2];
  logic [DATA_W-1:0] c_wdata [2];

  task automatic apply();
    p0.req = c_req[0]; p0.we = c_we[0]; p0.lock = c_lock[0]; p0.addr = c_addr[0]; p0.wdata = c_wdata[0];
    p1.req = c_req[1]; p1.we = c_we[1]; p1.lock = c_lock[1]; p1.addr = c_addr[1]; p1.wdata = c_wdata[1];
  endtask

  task automatic set_port(input int p, input logic req, input logic we, input logic lock,
                          input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
    c_req[p] = req; c_we[p] = we; c_lock[p] = lock; c_addr[p] = addr; c_wdata[p] = wdata;
  endtask

  task automatic model_reset();
    m_last   = 1;
    m_owner  = -1;
    m_streak = 0;
    for (int p = 0; p < 2; p++) begin
      exp_rvalid[p] = 1'b0;
      exp_rdata[p]  = '0;
    end
  endtask

  // One cycle: predict at the falling edge, compare, then advance the model
  // to what the coming rising edge will do.
  task automatic step();
    int win;
    @(negedge clk);
    if (!rst_n) model_reset();
    win = -1;
    if (rst_n) begin
      if (m_owner >= 0) begin
        if (c_req[m_owner]) win = m_owner;
      end else if (c_req[0] && c_req[1]) win = 1 - m_last;
      else if (c_req[0]) win = 0;
      else if (c_req[1]) win = 1;
    end
    m_gnt = 2'b00;
    if (win >= 0) m_gnt[win] = 1'b1;
    obs_gnt = {p1.gnt, p0.gnt};

    check_val("gnt",       DATA_W'(obs_gnt), DATA_W'(m_gnt));
    check_val("mem_write", DATA_W'(mem_write), DATA_W'((win >= 0) && c_we[win]));
    check_val("mem_read",  DATA_W'(mem_read),  DATA_W'((win >= 0) && !c_we[win]));
    check_val("mem_addr",  DATA_W'(mem_addr),  (win >= 0) ? DATA_W'(c_addr[win]) : '0);
    check_val("mem_wdata", mem_wdata,          (win >= 0) ? c_wdata[win] : '0);
    check_val("rvalid0",   DATA_W'(p0.rvalid), DATA_W'(exp_rvalid[0]));
    check_val("rvalid1",   DATA_W'(p1.rvalid), DATA_W'(exp_rvalid[1]));
    check_val("rdata0",    p0.rdata,           exp_rdata[0]);
    check_val("rdata1",    p1.rdata,           exp_rdata[1]);

    if (rst_n) begin
      exp_rvalid[0] = 1'b0;
      exp_rvalid[1] = 1'b0;
      if (win >= 0) begin
        if (c_we[win]) ref_mem[c_addr[win]] = c_wdata[win];
        else begin
          exp_rvalid[win] = 1'b1;
          exp_rdata[win]  = ref_mem[c_addr[win]];
        end
        if (m_owner == win) m_streak = (m_streak < MAX_LOCK) ? m_streak + 1 : MAX_LOCK;
        else                m_streak = 1;
        m_last = win;
        if (!c_lock[win])                                m_owner = -1;
        else if (c_req[1 - win] && m_streak >= MAX_LOCK) m_owner = -1;
        else                                             m_owner = win;
      end else begin
        m_owner = -1;
      end
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Port activity patterns for the tie and lock scenarios
  logic [1:0] t3_pat [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
  logic [1:0] t4_pat [6] = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    model_reset();

    // Reset with both ports requesting writes: nothing may be issued.
    set_port(0, 1'b1, 1'b1, 1'b0, 6'd1, 32'h1111_1111);
    set_port(1, 1'b1, 1'b1, 1'b0, 6'd2, 32'h2222_2222);
    apply();
    #1;
    step();
    check_val("rst_gnt",   DATA_W'(obs_gnt), '0);
    check_val("rst_mwr",   DATA_W'(mem_write), '0);
    next_cycle();
    rst_n = 1'b1;
    step();
    check_val("rst_first_gnt", DATA_W'(obs_gnt), DATA_W'(2'b01));
    next_cycle();

    // Single write then read back at the same address.
    set_port(1, 1'b0, 1'b0, 1'b0, '0, '0);
    set_port(0, 1'b1, 1'b1, 1'b0, 6'd5, 32'hDEAD_BEEF);
    apply(); step(); next_cycle();
    set_port(0, 1'b1, 1'b0, 1'b0, 6'd5, '0);
    apply(); step(); next_cycle();
    set_port(0, 1'b0, 1'b0, 1'b0, '0, '0);
    apply(); step();
    check_val("t2_rvalid0", DATA_W'(p0.rvalid), 32'd1);
    check_val("t2_rdata0",  p0.rdata, 32'hDEAD_BEEF);
    next_cycle();

    // Port 1 alone once so the following tie starts with port 0.
    set_port(1, 1'b1, 1'b0, 1'b0, 6'd9, '0);
    apply(); step(); next_cycle();
    for (int i = 0; i < 6; i++) begin
      set_port(0, 1'b1, 1'b0, 1'b0, ADDR_W'($urandom), '0);
      set_port(1, 1'b1, 1'b0, 1'b0, ADDR_W'($urandom), '0);
      apply(); step();
      check_val("t3_rr", DATA_W'(obs_gnt), DATA_W'(t3_pat[i]));
      next_cycle();
    end

    // Lock bound from a fresh reset.
    rst_n = 1'b0;
    step();
    next_cycle();
    rst_n = 1'b1;
    set_port(0, 1'b1, 1'b0, 1'b0, 6'd3, '0);
    set_port(1, 1'b1, 1'b0, 1'b1, 6'd4, '0);
    apply();
    for (int i = 0; i < 6; i++) begin
      step();
      check_val("t4_lock", DATA_W'(obs_gnt), DATA_W'(t4_pat[i]));
      next_cycle();
    end

    // Locked owner without contention, then the competitor arrives.
    set_port(1, 1'b0, 1'b0, 1'b0, '0, '0);
    set_port(0, 1'b1, 1'b1, 1'b1, 6'd7, 32'hA5A5_0000);
    for (int i = 0; i < 10; i++) begin
      c_wdata[0] = 32'hA5A5_0000 + DATA_W'(i);
      apply(); step();
      check_val("t5_lock0", DATA_W'(obs_gnt), DATA_W'(2'b01));
      next_cycle();
    end
    set_port(1, 1'b1, 1'b0, 1'b0, 6'd7, '0);
    apply(); step();
    check_val("t5_sat_last", DATA_W'(obs_gnt), DATA_W'(2'b01));
    next_cycle();
    step();
    check_val("t5_other", DATA_W'(obs_gnt), DATA_W'(2'b10));
    next_cycle();

    // Reset right after a read grant drops the pending read data.
    set_port(1, 1'b0, 1'b0, 1'b0, '0, '0);
    set_port(0, 1'b1, 1'b0, 1'b0, 6'd5, '0);
    apply(); step(); next_cycle();
    rst_n = 1'b0;
    #1;
    check_val("t6_rvalid0", DATA_W'(p0.rvalid), '0);
    check_val("t6_rdata0",  p0.rdata, '0);
    step();
    next_cycle();
    rst_n = 1'b1;

    // Random traffic: a port keeps its request stable until granted.
    for (int p = 0; p < 2; p++) c_req[p] = 1'b0;
    m_gnt = 2'b00;
    for (int i = 0; i < 600; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (!c_req[p] || m_gnt[p]) begin
          c_req[p]   = ($urandom_range(0, 3) != 0);
          c_we[p]    = $urandom_range(0, 1) == 1;
          c_addr[p]  = ADDR_W'($urandom_range(0, 7));
          c_wdata[p] = $urandom;
        end
        c_lock[p] = $urandom_range(0, 1) == 1;
      end
      if (i == 300) rst_n = 1'b0;
      if (i == 302) rst_n = 1'b1;
      apply();
      step();
      next_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
